// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data RAM between the CPU
// MEM stage and an external host/DMA port.
//   - The CPU has fixed priority. After the host has lost STARVE_LIMIT
//     consecutive cycles, the host wins the next one.
//   - A CPU that loses arbitration sees cpu_stall and holds its request.
//   - Read data returns one cycle after the grant, tagged with the
//     requester's rvalid. rdata is forced to 0 when rvalid is low.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata             CPU access request
//   cpu_stall, cpu_rvalid, cpu_rdata  CPU stall and load return
//   host_req/we/addr/wdata            host request, held until host_gnt
//   host_gnt, host_rvalid, host_rdata host accept and read return
//   mem_en/we/addr/wdata, mem_rdata   RAM interface (read latency 1)
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0] starve_cnt;
    logic                 cpu_rd_pend;
    logic                 host_rd_pend;
    logic                 host_wins;
    logic                 cpu_gnt;

    // Grants are qualified with rst_n so that the RAM interface and the
    // handshake outputs are quiet for the whole time reset is asserted,
    // not only after the first clock edge.
    always_comb begin
        host_wins = rst_n & host_req & (~cpu_req | (starve_cnt == LIMIT));
        cpu_gnt   = rst_n & cpu_req & ~host_wins;
        host_gnt  = host_wins;
        cpu_stall = rst_n & cpu_req & ~cpu_gnt;
        mem_en    = cpu_gnt | host_wins;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (host_wins) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // Starvation counter: counts consecutive cycles in which the host asked
    // but was not granted. It saturates at the limit and clears on any
    // host grant or when the host stops requesting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (host_req && !host_wins) begin
            if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CNT_WIDTH'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // Read return tracking. Only one port is granted per cycle, so at most
    // one pending flag is ever set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rd_pend  <= 1'b0;
            host_rd_pend <= 1'b0;
        end else begin
            cpu_rd_pend  <= cpu_gnt & ~cpu_we;
            host_rd_pend <= host_wins & ~host_we;
        end
    end

    always_comb begin
        cpu_rvalid  = cpu_rd_pend;
        host_rvalid = host_rd_pend;
        cpu_rdata   = cpu_rd_pend  ? mem_rdata : '0;
        host_rdata  = host_rd_pend ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter.
// Two instances share the same stimulus: u0 uses STARVE_LIMIT=4 and u1 uses
// STARVE_LIMIT=1. Each vector selects which instance is checked. Every
// instance has its own behavioural RAM. Expected read data comes from
// exp_ram, a shadow copy updated from the expected writes.
module tb_dmem_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cpu_req, cpu_we, host_req, host_we;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;

    logic          cpu_stall0, cpu_rvalid0, host_gnt0, host_rvalid0, mem_en0, mem_we0;
    logic [DW-1:0] cpu_rdata0, host_rdata0, mem_wdata0, mem_rdata0;
    logic [AW-1:0] mem_addr0;
    logic          cpu_stall1, cpu_rvalid1, host_gnt1, host_rvalid1, mem_en1, mem_we1;
    logic [DW-1:0] cpu_rdata1, host_rdata1, mem_wdata1, mem_rdata1;
    logic [AW-1:0] mem_addr1;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4), .CNT_WIDTH(4)) u0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall0), .cpu_rvalid(cpu_rvalid0), .cpu_rdata(cpu_rdata0),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt0), .host_rvalid(host_rvalid0), .host_rdata(host_rdata0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0)
    );

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(1), .CNT_WIDTH(4)) u1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt1), .host_rvalid(host_rvalid1), .host_rdata(host_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    // Behavioural single-port synchronous RAMs, one per instance.
    logic [DW-1:0] ram0 [65536];
    logic [DW-1:0] ram1 [65536];
    logic [DW-1:0] exp_ram [65536];

    always @(posedge clk) begin
        if (mem_en0) begin
            if (mem_we0) ram0[mem_addr0] <= mem_wdata0;
            else         mem_rdata0 <= ram0[mem_addr0];
        end
    end

    always @(posedge clk) begin
        if (mem_en1) begin
            if (mem_we1) ram1[mem_addr1] <= mem_wdata1;
            else         mem_rdata1 <= ram1[mem_addr1];
        end
    end

    typedef struct {
        bit          sel;
        bit          rst;
        logic        creq, cwe;
        logic [15:0] caddr, cwdata;
        logic        hreq, hwe;
        logic [15:0] haddr, hwdata;
        logic        e_stall, e_hgnt, e_en, e_we;
        logic [15:0] e_addr, e_wdata;
        logic [3:0]  e_cnt;
    } vec_t;

    typedef struct {
        bit          is_host;
        logic [15:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void add(bit sel, bit rst,
                                logic creq, logic cwe, logic [15:0] ca, logic [15:0] cd,
                                logic hreq, logic hwe, logic [15:0] ha, logic [15:0] hd,
                                logic es, logic eh, logic ee, logic ew,
                                logic [15:0] ea, logic [15:0] ed, int ec);
        vec_t v;
        v.sel = sel; v.rst = rst;
        v.creq = creq; v.cwe = cwe; v.caddr = ca; v.cwdata = cd;
        v.hreq = hreq; v.hwe = hwe; v.haddr = ha; v.hwdata = hd;
        v.e_stall = es; v.e_hgnt = eh; v.e_en = ee; v.e_we = ew;
        v.e_addr = ea; v.e_wdata = ed; v.e_cnt = 4'(ec);
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        exp_t        e;
        logic        a_stall, a_hgnt, a_en, a_we, a_crv, a_hrv;
        logic [15:0] a_addr, a_wdata, a_crd, a_hrd;
        logic [3:0]  a_cnt;
        logic        x_crv, x_hrv;
        logic [15:0] x_crd, x_hrd;

        for (int i = 0; i < 65536; i++) begin
            ram0[i] = '0; ram1[i] = '0; exp_ram[i] = '0;
        end
        // Preload the same contents into both RAMs and the shadow copy.
        ram0[16'h0010] = 16'hBEEF; ram0[16'h0020] = 16'h1111; ram0[16'h0030] = 16'h2222;
        ram0[16'h0040] = 16'h3333; ram0[16'h0100] = 16'hA0A0; ram0[16'h0200] = 16'hB0B0;
        ram0[16'h0300] = 16'hC0C0; ram0[16'h0400] = 16'hD0D0;
        for (int i = 0; i < 65536; i++) begin
            ram1[i]    = ram0[i];
            exp_ram[i] = ram0[i];
        end

        // sel rst | creq cwe caddr cwdata | hreq hwe haddr hwdata | stall hgnt en we addr wdata cnt
        add(0,1, 1,0,16'h0010,16'h0000, 1,0,16'h0040,16'h0000, 0,0,0,0,16'h0000,16'h0000,0); // reset state
        add(0,0, 1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 0,0,1,0,16'h0010,16'h0000,0); // CPU load
        add(0,0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000,0);
        add(0,0, 0,0,16'h0000,16'h0000, 1,1,16'hFFFF,16'h1234, 0,1,1,1,16'hFFFF,16'h1234,0); // host write
        add(0,0, 0,0,16'h0000,16'h0000, 1,0,16'hFFFF,16'h0000, 0,1,1,0,16'hFFFF,16'h0000,0); // host read
        add(0,0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000,0);
        // continuous dual requests, limit 4: C C C C H C C C C H
        add(0,0, 1,0,16'h0020,16'h00C1, 1,0,16'h0040,16'h00D1, 0,0,1,0,16'h0020,16'h00C1,0);
        add(0,0, 1,0,16'h0030,16'h00C1, 1,0,16'h0040,16'h00D1, 0,0,1,0,16'h0030,16'h00C1,1);
        add(0,0, 1,0,16'h0020,16'h00C1, 1,0,16'h0040,16'h00D1, 0,0,1,0,16'h0020,16'h00C1,2);
        add(0,0, 1,0,16'h0030,16'h00C1, 1,0,16'h0040,16'h00D1, 0,0,1,0,16'h0030,16'h00C1,3);
        add(0,0, 1,0,16'h0010,16'h00C1, 1,0,16'h0040,16'h00D1, 1,1,1,0,16'h0040,16'h00D1,4);
        add(0,0, 1,0,16'h0010,16'h00C1, 1,0,16'h0040,16'h00D1, 0,0,1,0,16'h0010,16'h00C1,0); // held CPU completes
        add(0,0, 1,0,16'h0020,16'h00C1, 1,0,16'h0040,16'h00D1, 0,0,1,0,16'h0020,16'h00C1,1);
        add(0,0, 1,0,16'h0030,16'h00C1, 1,0,16'h0040,16'h00D1, 0,0,1,0,16'h0030,16'h00C1,2);
        add(0,0, 1,0,16'h0020,16'h00C1, 1,0,16'h0040,16'h00D1, 0,0,1,0,16'h0020,16'h00C1,3);
        add(0,0, 1,0,16'h0010,16'h00C1, 1,0,16'h0040,16'h00D1, 1,1,1,0,16'h0040,16'h00D1,4);
        // cpu_req drops while the counter is non-zero
        add(0,0, 1,0,16'h0030,16'h00C1, 1,1,16'h0050,16'h5555, 0,0,1,0,16'h0030,16'h00C1,0);
        add(0,0, 1,0,16'h0020,16'h00C1, 1,1,16'h0050,16'h5555, 0,0,1,0,16'h0020,16'h00C1,1);
        add(0,0, 0,0,16'h0000,16'h0000, 1,1,16'h0050,16'h5555, 0,1,1,1,16'h0050,16'h5555,2);
        add(0,0, 1,1,16'h0060,16'h6666, 0,0,16'h0000,16'h0000, 0,0,1,1,16'h0060,16'h6666,0);
        add(0,0, 1,0,16'h0050,16'h0000, 0,0,16'h0000,16'h0000, 0,0,1,0,16'h0050,16'h0000,0);
        // reset while a CPU load is pending
        add(0,0, 1,0,16'h0060,16'h0000, 0,0,16'h0000,16'h0000, 0,0,1,0,16'h0060,16'h0000,0);
        add(0,1, 1,0,16'h0010,16'h0000, 1,0,16'h0040,16'h0000, 0,0,0,0,16'h0000,16'h0000,0);
        add(0,0, 1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 0,0,1,0,16'h0010,16'h0000,0);
        add(0,0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000,0);
        // limit 1 instance: alternating grants
        add(1,0, 1,0,16'h0100,16'h0000, 1,0,16'h0200,16'h0000, 0,0,1,0,16'h0100,16'h0000,0);
        add(1,0, 1,0,16'h0100,16'h0000, 1,0,16'h0200,16'h0000, 1,1,1,0,16'h0200,16'h0000,1);
        add(1,0, 1,0,16'h0100,16'h0000, 1,0,16'h0400,16'h0000, 0,0,1,0,16'h0100,16'h0000,0);
        add(1,0, 1,0,16'h0300,16'h0000, 1,0,16'h0400,16'h0000, 1,1,1,0,16'h0400,16'h0000,1);
        add(1,0, 1,0,16'h0300,16'h0000, 1,0,16'h0200,16'h0000, 0,0,1,0,16'h0300,16'h0000,0);
        add(1,0, 1,0,16'h0400,16'h0000, 1,0,16'h0200,16'h0000, 1,1,1,0,16'h0200,16'h0000,1);
        add(1,0, 1,0,16'h0400,16'h0000, 0,0,16'h0000,16'h0000, 0,0,1,0,16'h0400,16'h0000,0);
        add(1,0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000,16'h0000,0);

        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(posedge clk);
            #1;
            rst_n     = ~v.rst;
            cpu_req   = v.creq;  cpu_we  = v.cwe;  cpu_addr  = v.caddr;  cpu_wdata  = v.cwdata;
            host_req  = v.hreq;  host_we = v.hwe;  host_addr = v.haddr;  host_wdata = v.hwdata;
            @(negedge clk);

            a_stall = v.sel ? cpu_stall1   : cpu_stall0;
            a_hgnt  = v.sel ? host_gnt1    : host_gnt0;
            a_en    = v.sel ? mem_en1      : mem_en0;
            a_we    = v.sel ? mem_we1      : mem_we0;
            a_addr  = v.sel ? mem_addr1    : mem_addr0;
            a_wdata = v.sel ? mem_wdata1   : mem_wdata0;
            a_crv   = v.sel ? cpu_rvalid1  : cpu_rvalid0;
            a_hrv   = v.sel ? host_rvalid1 : host_rvalid0;
            a_crd   = v.sel ? cpu_rdata1   : cpu_rdata0;
            a_hrd   = v.sel ? host_rdata1  : host_rdata0;
            a_cnt   = v.sel ? u1.starve_cnt : u0.starve_cnt;

            chk("cpu_stall", i, 32'(a_stall), 32'(v.e_stall));
            chk("host_gnt",  i, 32'(a_hgnt),  32'(v.e_hgnt));
            chk("mem_en",    i, 32'(a_en),    32'(v.e_en));
            chk("mem_we",    i, 32'(a_we),    32'(v.e_we));
            chk("mem_addr",  i, 32'(a_addr),  32'(v.e_addr));
            chk("mem_wdata", i, 32'(a_wdata), 32'(v.e_wdata));
            chk("starve_cnt",i, 32'(a_cnt),   32'(v.e_cnt));

            // A reset drops any read still in flight.
            if (v.rst) sb.delete();
            x_crv = 1'b0; x_hrv = 1'b0; x_crd = '0; x_hrd = '0;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.is_host) begin x_hrv = 1'b1; x_hrd = e.data; end
                else           begin x_crv = 1'b1; x_crd = e.data; end
            end
            chk("cpu_rvalid",  i, 32'(a_crv), 32'(x_crv));
            chk("cpu_rdata",   i, 32'(a_crd), 32'(x_crd));
            chk("host_rvalid", i, 32'(a_hrv), 32'(x_hrv));
            chk("host_rdata",  i, 32'(a_hrd), 32'(x_hrd));

            if (!v.rst && v.e_en) begin
                if (v.e_we) begin
                    exp_ram[v.e_addr] = v.e_wdata;
                end else begin
                    e.is_host = v.e_hgnt;
                    e.data    = exp_ram[v.e_addr];
                    sb.push_back(e);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
